mult_div_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run over WIDTH cycles behind a start/busy/done handshake, so the combinational 64-bit product and divide paths in the execute stage are removed. The controller stalls MFHI/MFLO and further mult/div ops on `busy`.

---
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU (WIDTH-cycle shift-add / restoring divide,
// followed by one sign-fix cycle) and the single-cycle MTHI/MTLO moves.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start, flush   op request (taken only when idle), cancel of an in-flight op
//   op             000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   op_a, op_b     rs / rt operand values
//   busy, done     op in progress / one-cycle HI/LO update pulse
//   div_by_zero    sticky zero-divisor flag, cleared by the next accepted mult/div
//   hi, lo         HI / LO registers
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic             is_div;
    logic             neg_q;    // product / quotient must be negated
    logic             neg_r;    // remainder must be negated
    logic             dz;       // divisor was zero

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_trial;
    logic [AW-1:0]    acc_step;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes, one iteration step, and final sign correction.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & op_a[WIDTH-1];
        b_neg     = signed_op & op_b[WIDTH-1];
        a_mag     = a_neg ? WIDTH'(-op_a) : op_a;
        b_mag     = b_neg ? WIDTH'(-op_b) : op_b;

        mul_sum   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Trial subtract of the divisor from {remainder, next dividend bit}; MSB set means borrow.
        div_trial = {1'b0, acc[AW-1:WIDTH-1]} - {2'b00, opnd};

        if (is_div) begin
            acc_step = div_trial[WIDTH+1] ? {acc[AW-2:0], 1'b0}
                                          : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end

        prod_fix = neg_q ? AW'(-acc) : acc;
        quo_fix  = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? WIDTH'(-acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (!op[2]) begin
                            state       <= CALC;
                            busy        <= 1'b1;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            is_div      <= op[1];
                            neg_q       <= a_neg ^ b_neg;
                            dz          <= op[1] && (op_b == '0);
                            if (op[1]) begin
                                acc   <= {{WIDTH{1'b0}}, a_mag};
                                opnd  <= b_mag;
                                neg_r <= a_neg;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, b_mag};
                                opnd  <= a_mag;
                                neg_r <= 1'b0;
                            end
                        end else if (!op[1]) begin
                            if (op[0]) begin
                                lo <= op_a;
                            end else begin
                                hi <= op_a;
                            end
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_step;
                        cnt <= CW'(cnt + 1'b1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done        <= 1'b1;
                        div_by_zero <= dz;
                        if (is_div) begin
                            // Zero divisor: remainder path already reproduces op_a; quotient forced to all ones.
                            hi <= rem_fix;
                            lo <= dz ? '1 : quo_fix;
                        end else begin
                            hi <= prod_fix[AW-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
